spi_cmd_master: RTL

- FPGA-side SPI master that issues 32-bit opcode frames to an SPI command slave. It is the initiator for the NOP/INIT/WR_INVERTED/RD_INVERTED/WR_LEDS/RD_LEDS/WR_VEC/RD_VEC protocol.
- Used for on-board loopback testing of the slave design and for driving a second FPGA/DDS board.
- Accepts one command per handshake, serialises it, and generates the follow-up frames that read opcodes need. Returns 24-bit responses on a valid-only stream.

---
 rtl/spi_cmd_pkg.sv | 39 +++
 rtl/spi_sck_gen.sv | 57 +++++
 rtl/spi_cmd_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_cmd_pkg : opcodes, frame sizes and FSM states for the SPI      |
// |               command master.                                      |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_INIT        = 8'h01;
    localparam logic [7:0] OP_WR_INVERTED = 8'h02;
    localparam logic [7:0] OP_RD_INVERTED = 8'h03;
    localparam logic [7:0] OP_WR_LEDS     = 8'h04;
    localparam logic [7:0] OP_RD_LEDS     = 8'h05;
    localparam logic [7:0] OP_WR_VEC      = 8'h06;
    localparam logic [7:0] OP_RD_VEC      = 8'h07;

    localparam int FRAME_BITS = 32;
    localparam int RSP_BITS   = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // Number of NOP frames that follow the command frame to clock out read data.
    function automatic logic [2:0] follow_frames(input logic [7:0] op, input int vec_words);
        case (op)
            OP_RD_INVERTED, OP_RD_LEDS: return 3'd1;
            OP_RD_VEC:                  return 3'(vec_words);
            default:                    return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_sck_gen : CLK_DIV half-period timer with SCK and edge strobes. |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic toggle_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sck
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;

    // tick/rise/fall describe what happens on the coming clk edge.
    always_comb begin
        tick  = en && (cnt_q == CW'(CLK_DIV - 1));
        rise  = tick && toggle_en && !sck_q;
        fall  = tick && toggle_en && sck_q;
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            if (toggle_en) begin
                sck_d = !sck_q;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule
`default_nettype wire

// File: rtl/spi_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_cmd_master : mode-0 SPI master for 32-bit opcode frames with   |
// |                  read follow-up frames. Option: SPI_CMD_MASTER_TIMEOUT_EN |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module spi_cmd_master
    import spi_cmd_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int VEC_WORDS  = 4
`ifdef SPI_CMD_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_FRAMES = 16
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [23:0] cmd_data,
    output logic        rsp_valid,
    output logic [23:0] rsp_data,
    output logic        rsp_last,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_SS,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
`ifdef SPI_CMD_MASTER_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int BW = $clog2(FRAME_BITS);

    state_e                state_q, state_d;
    logic [7:0]            op_q, op_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [RSP_BITS-1:0]   rx_q, rx_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [2:0]            frame_q, frame_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  ss_q, ss_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_last_q, rsp_last_d;
    logic [RSP_BITS-1:0]   rsp_data_q, rsp_data_d;
    logic                  sck_en, sck_toggle, tick, rise, fall, sck;
    logic [2:0]            follow;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (sck_en),
        .toggle_en (sck_toggle),
        .tick      (tick),
        .rise      (rise),
        .fall      (fall),
        .sck       (sck)
    );

    assign follow = follow_frames(op_q, VEC_WORDS);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        gap_d       = gap_q;
        ss_d        = ss_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_data_d  = rsp_data_q;
        sck_en      = 1'b0;
        sck_toggle  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    tx_d    = {cmd_data, cmd_op};
                    bit_d   = '0;
                    frame_d = 3'd0;
                    ss_d    = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                sck_en = 1'b1;
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sck_en     = 1'b1;
                sck_toggle = 1'b1;
                // Only the first RSP_BITS sampled bits form the response word.
                if (rise && (bit_q < BW'(RSP_BITS))) begin
                    rx_d = {rx_q[RSP_BITS-2:0], SPI_MISO};
                end
                if (fall) begin
                    tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BW'(FRAME_BITS - 1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                sck_en = 1'b1;
                if (tick) begin
                    ss_d    = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                    if (frame_q != 3'd0) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rx_q;
                        rsp_last_d  = (frame_q == follow);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    if (frame_q < follow) begin
                        frame_d = frame_q + 3'd1;
                        tx_d    = '0;
                        bit_d   = '0;
                        ss_d    = 1'b0;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            gap_q       <= '0;
            ss_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            gap_q       <= gap_d;
            ss_q        <= ss_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign SPI_SCK   = sck;
    assign SPI_SS    = ss_q;
    assign SPI_MOSI  = tx_q[FRAME_BITS-1];

`ifdef SPI_CMD_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

    logic [TW-1:0] miss_q, miss_d;
    logic          timeout_q, timeout_d;

    // Consecutive all-ones read responses mean the slave is not driving MISO.
    always_comb begin
        miss_d    = miss_q;
        timeout_d = timeout_q;
        if (rsp_valid_d) begin
            if (rsp_data_d == '1) begin
                if (miss_q != TW'(TIMEOUT_FRAMES)) begin
                    miss_d = miss_q + TW'(1);
                end
            end else begin
                miss_d = '0;
            end
        end
        if (miss_d == TW'(TIMEOUT_FRAMES)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            miss_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            miss_q    <= miss_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

endmodule
`default_nettype wire
